snn_timestep_sequencer: RTL and testbench
=========================================

SNN_TIMESTEP_SEQUENCER -- requirements
Module: snn_timestep_sequencer

Interface
REQ-001 SHALL have parameter M_IN, default 24, meaning input spike frame width.
REQ-002 SHALL have parameter N_OUT, default 2, meaning output-layer neuron count.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, meaning snn_enable cycles per timestep (legal 1..15).
REQ-004 SHALL have ports: clk in 1, single clock; reset_n in 1, asynchronous, active-low.
REQ-005 SHALL have ports: in_valid in 1, frame offered; in_ready out 1, frame accepted when both high; in_spikes in M_IN, frame.
REQ-006 SHALL have port net_clear in 1, request to clear network state.
REQ-007 SHALL have ports: snn_reset out 1; snn_enable out 1; snn_delay_clk out 1; snn_input_spikes out M_IN; snn_output_spikes in N_OUT.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_spikes out N_OUT; out_timestep out 16, index of the timestep that produced out_spikes.
REQ-009 SHALL have ports: clear_counts in 1; spike_counts out 8*N_OUT, neuron k in bits [8k+7:8k].

Function
REQ-010 SHALL implement states IDLE, RUN, TICK, OUTPUT, CLEAR.
REQ-011 In IDLE, in_ready SHALL be 1 unless net_clear is 1; in every other state in_ready SHALL be 0.
REQ-012 IDLE with net_clear=1 SHALL go to CLEAR, taking priority over a simultaneous in_valid, which is not accepted.
REQ-013 CLEAR SHALL last exactly one cycle with snn_reset=1, then return to IDLE; snn_reset SHALL be 0 in all other states.
REQ-014 On acceptance, SHALL latch in_spikes into snn_input_spikes, clear the spike accumulator, and go to RUN; snn_input_spikes SHALL hold until the next acceptance.
REQ-015 RUN SHALL last exactly SETTLE_CYCLES cycles with snn_enable=1, counted by a 4-bit settle counter; snn_enable SHALL be 0 in all other states.
REQ-016 During RUN, accumulator SHALL OR in snn_output_spikes each cycle.
REQ-017 TICK SHALL last one cycle with snn_delay_clk=1 and snn_enable=0; snn_delay_clk SHALL be 0 in all other states.
REQ-018 Leaving TICK SHALL load out_spikes from the accumulator, load out_timestep from the timestep counter, increment the counter, and enter OUTPUT.
REQ-019 Latency: frame accepted at edge T -> snn_enable high cycles T+1..T+SETTLE_CYCLES, snn_delay_clk high cycle T+SETTLE_CYCLES+1, out_valid high from cycle T+SETTLE_CYCLES+2.
REQ-020 OUTPUT SHALL hold out_valid=1 and stable out_spikes/out_timestep until out_ready=1, then go to IDLE; with out_ready held high OUTPUT lasts one cycle.
REQ-021 out_spikes/out_timestep SHALL remain stable after out_valid falls, until the next TICK exit.
REQ-022 The timestep counter SHALL be 16 bits and wrap 0xFFFF -> 0x0000; it SHALL NOT change on CLEAR.
REQ-023 net_clear outside IDLE SHALL be ignored and not remembered.

Reset
REQ-024 reset_n=0 SHALL asynchronously force state IDLE; settle counter, timestep counter, accumulator, snn_input_spikes, out_spikes, out_timestep, spike_counts to 0; snn_reset, snn_enable, snn_delay_clk, out_valid to 0.
REQ-025 Reset asserted mid-RUN or mid-OUTPUT SHALL abandon the timestep with no out_valid pulse; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-026 With macro SNN_SPIKE_COUNT_EN defined, each output neuron SHALL have an 8-bit saturating counter incremented on TICK exit when its out_spikes bit loads as 1, holding at 255.
REQ-027 With SNN_SPIKE_COUNT_EN defined, clear_counts=1 SHALL zero all counters, taking priority over a same-cycle increment.
REQ-028 Without SNN_SPIKE_COUNT_EN, spike_counts SHALL be constant 0, clear_counts SHALL be ignored, and no counter flops SHALL be synthesized.

Verification
REQ-029 Frame 0xABCDEF accepted, snn_output_spikes=2'b01 in RUN cycle 2 only, out_ready=1 -> snn_enable 4 cycles, snn_delay_clk 1 cycle, out_spikes=2'b01, out_timestep=0, out_valid at T+6 for 1 cycle.
REQ-030 out_ready low 5 cycles in OUTPUT -> out_valid held 5+ cycles, outputs stable, in_ready 0; new in_valid not accepted until return to IDLE.
REQ-031 net_clear and in_valid both high in IDLE -> snn_reset one cycle, frame not accepted, accepted on the following IDLE cycle.
REQ-032 Preload timestep 0xFFFF via 65535 frames or force -> out_timestep=0xFFFF, next out_timestep=0x0000.
REQ-033 reset_n low during RUN cycle 2 -> all outputs 0 immediately, no out_valid, in_ready=1 after release.
REQ-034 SNN_SPIKE_COUNT_EN: 300 timesteps with neuron 1 spiking -> spike_counts[15:8]=255; clear_counts -> 0; macro undefined -> spike_counts always 0.

Source files
------------

// File: rtl/snn_timestep_sequencer.sv
// Timestep sequencer for a spiking-network core: accepts an input spike frame, settles the
// network, ticks its delay line, and presents the OR of output spikes. SNN_SPIKE_COUNT_EN adds per-neuron spike counters.
module snn_timestep_sequencer #(
  parameter int M_IN          = 24,
  parameter int N_OUT         = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [M_IN-1:0]    in_spikes,
  input  logic               net_clear,
  output logic               snn_reset,
  output logic               snn_enable,
  output logic               snn_delay_clk,
  output logic [M_IN-1:0]    snn_input_spikes,
  input  logic [N_OUT-1:0]   snn_output_spikes,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_OUT-1:0]   out_spikes,
  output logic [15:0]        out_timestep,
  input  logic               clear_counts,
  output logic [8*N_OUT-1:0] spike_counts
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RUN    = 3'd1;
  localparam logic [2:0] TICK   = 3'd2;
  localparam logic [2:0] OUTPUT = 3'd3;
  localparam logic [2:0] CLEAR  = 3'd4;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [2:0]       state;
  logic [3:0]       settle_cnt;
  logic [15:0]      ts_cnt;
  logic [N_OUT-1:0] acc;

  // in_ready is gated by reset_n so every output reads 0 while reset is held.
  assign in_ready      = reset_n && (state == IDLE) && !net_clear;
  assign snn_reset     = (state == CLEAR);
  assign snn_enable    = (state == RUN);
  assign snn_delay_clk = (state == TICK);
  assign out_valid     = (state == OUTPUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      ts_cnt           <= '0;
      acc              <= '0;
      snn_input_spikes <= '0;
      out_spikes       <= '0;
      out_timestep     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (net_clear) begin
            state <= CLEAR;
          end else if (in_valid) begin
            state            <= RUN;
            snn_input_spikes <= in_spikes;
            acc              <= '0;
            settle_cnt       <= '0;
          end
        end
        RUN: begin
          acc <= acc | snn_output_spikes;
          if (settle_cnt == SETTLE_LAST) begin
            state <= TICK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        TICK: begin
          out_spikes   <= acc;
          out_timestep <= ts_cnt;
          ts_cnt       <= ts_cnt + 16'd1;
          state        <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        CLEAR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SNN_SPIKE_COUNT_EN
  logic [7:0] cnt [N_OUT];

  // Counters sample acc on TICK exit, the same value loaded into out_spikes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (clear_counts) begin
          cnt[k] <= '0;
        end else if ((state == TICK) && acc[k] && (cnt[k] != '1)) begin
          cnt[k] <= cnt[k] + 8'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
    assign spike_counts[8*g +: 8] = cnt[g];
  end
`else
  logic unused_clear_counts;
  assign unused_clear_counts = clear_counts;
  assign spike_counts        = '0;
`endif

endmodule

// File: tb/tb_snn_timestep_sequencer.sv
// Directed self-checking bench for snn_timestep_sequencer (default parameters).
module tb_snn_timestep_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_spikes;
  logic        net_clear;
  logic        snn_reset;
  logic        snn_enable;
  logic        snn_delay_clk;
  logic [23:0] snn_input_spikes;
  logic [1:0]  snn_output_spikes;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_spikes;
  logic [15:0] out_timestep;
  logic        clear_counts;
  logic [15:0] spike_counts;

  int checks = 0;
  int errors = 0;

`ifdef SNN_SPIKE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  snn_timestep_sequencer #(.M_IN(24), .N_OUT(2), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes),
    .net_clear(net_clear),
    .snn_reset(snn_reset), .snn_enable(snn_enable), .snn_delay_clk(snn_delay_clk),
    .snn_input_spikes(snn_input_spikes), .snn_output_spikes(snn_output_spikes),
    .out_valid(out_valid), .out_ready(out_ready), .out_spikes(out_spikes),
    .out_timestep(out_timestep),
    .clear_counts(clear_counts), .spike_counts(spike_counts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for out_valid with out_ready high, captures outputs, lets OUTPUT complete.
  task automatic wait_out(output logic [1:0] os, output logic [15:0] ots);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    os  = out_spikes;
    ots = out_timestep;
    @(negedge clk);
  endtask

  task automatic do_frame(input logic [23:0] f, input logic [1:0] sp,
                          output logic [1:0] os, output logic [15:0] ots);
    int n = 0;
    in_valid = 1'b1;
    in_spikes = f;
    snn_output_spikes = sp;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(os, ots);
    snn_output_spikes = '0;
  endtask

  logic [1:0]  os;
  logic [15:0] ots;
  logic [15:0] sc;
  int          seen;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_spikes = '0; net_clear = 1'b0;
    snn_output_spikes = '0; out_ready = 1'b1; clear_counts = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_enable", 32'(snn_enable), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_spk", 32'(snn_input_spikes), 32'd0);
    chk("rst_counts", 32'(spike_counts), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Basic timestep: spike on neuron 0 in RUN cycle 2 only.
    in_valid = 1'b1; in_spikes = 24'hABCDEF;
    @(negedge clk);                               // T+1
    in_valid = 1'b0;
    chk("t1_in_spk", 32'(snn_input_spikes), 32'hABCDEF);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("run%0d_enable", i), 32'(snn_enable), 32'd1);
      chk($sformatf("run%0d_delay", i), 32'(snn_delay_clk), 32'd0);
      @(negedge clk);
      snn_output_spikes = (i == 1) ? 2'b01 : 2'b00;
    end
    chk("tick_delay", 32'(snn_delay_clk), 32'd1);  // T+5
    chk("tick_enable", 32'(snn_enable), 32'd0);
    chk("tick_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);                               // T+6
    chk("t6_out_valid", 32'(out_valid), 32'd1);
    chk("t6_out_spikes", 32'(out_spikes), 32'h1);
    chk("t6_out_ts", 32'(out_timestep), 32'h0);
    @(negedge clk);                               // T+7
    chk("t7_out_valid", 32'(out_valid), 32'd0);
    chk("t7_in_ready", 32'(in_ready), 32'd1);
    chk("t7_hold_spikes", 32'(out_spikes), 32'h1);

    // Backpressure: out_ready low for 5 OUTPUT cycles, new frame offered meanwhile.
    in_valid = 1'b1; in_spikes = 24'h555555; out_ready = 1'b0; snn_output_spikes = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    snn_output_spikes = '0;
    repeat (2) @(negedge clk);                    // T+6
    in_valid = 1'b1; in_spikes = 24'h123456;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_spikes", 32'(out_spikes), 32'h2);
      chk("bp_out_ts", 32'(out_timestep), 32'h1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_in_spk", 32'(snn_input_spikes), 32'h555555);
      if (i == 4) out_ready = 1'b1;
      @(negedge clk);
    end
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_new_in_spk", 32'(snn_input_spikes), 32'h123456);
    chk("bp_new_enable", 32'(snn_enable), 32'd1);
    wait_out(os, ots);
    chk("bp2_ts", 32'(ots), 32'h2);
    chk("bp2_spikes", 32'(os), 32'h0);

    // net_clear wins over in_valid in IDLE; counter survives CLEAR.
    net_clear = 1'b1; in_valid = 1'b1; in_spikes = 24'h0F0F0F;
    #1;
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("clr_snn_reset", 32'(snn_reset), 32'd1);
    chk("clr_in_spk", 32'(snn_input_spikes), 32'h123456);
    net_clear = 1'b0;
    @(negedge clk);
    chk("clr_done", 32'(snn_reset), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("clr_accept", 32'(snn_input_spikes), 32'h0F0F0F);
    net_clear = 1'b1;                            // ignored outside IDLE
    @(negedge clk);
    net_clear = 1'b0;
    @(negedge clk);
    chk("clr_ignored", 32'(snn_reset), 32'd0);
    wait_out(os, ots);
    chk("clr_ts", 32'(ots), 32'h3);
    #1;
    chk("clr_not_remembered", 32'(in_ready), 32'd1);

    // Timestep wrap.
    force dut.ts_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.ts_cnt;
    do_frame(24'h000001, 2'b00, os, ots);
    chk("wrap_ffff", 32'(ots), 32'hFFFF);
    do_frame(24'h000002, 2'b00, os, ots);
    chk("wrap_0000", 32'(ots), 32'h0);

    // Reset during RUN cycle 2.
    in_valid = 1'b1; in_spikes = 24'hABCDEF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mr_enable", 32'(snn_enable), 32'd0);
    chk("mr_in_spk", 32'(snn_input_spikes), 32'h0);
    chk("mr_out_ts", 32'(out_timestep), 32'h0);
    chk("mr_out_spikes", 32'(out_spikes), 32'h0);
    chk("mr_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mr_release_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("mr_no_valid", 32'(seen), 32'd0);
    do_frame(24'h00000F, 2'b00, os, ots);
    chk("mr_ts_restart", 32'(ots), 32'h0);

    // Spike counters.
    repeat (3) do_frame(24'h000010, 2'b11, os, ots);
    chk("cnt_three", 32'(spike_counts), CNT_EN ? 32'h0303 : 32'h0);
    for (int i = 0; i < 300; i++) do_frame(24'h000020, 2'b10, os, ots);
    sc = spike_counts;
    chk("cnt_sat_n1", 32'(sc[15:8]), CNT_EN ? 32'd255 : 32'd0);
    chk("cnt_n0", 32'(sc[7:0]), CNT_EN ? 32'd3 : 32'd0);
    clear_counts = 1'b1;
    @(negedge clk);
    clear_counts = 1'b0;
    chk("cnt_cleared", 32'(spike_counts), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
